// File: rtl/ps2_frame_receiver.sv
//------------------------------------------------------------------------------
// ps2_frame_receiver: PS/2 frame deserialiser with byte FIFO and valid/ready out
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_frame_receiver #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          ready,
    output logic                          valid,
    output logic [7:0]                    data_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic             clk_s1, clk_s2, clk_s3;
    logic             dat_s1, dat_s2;
    logic             fall;
    logic [1:0]       state, state_next;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par_bit;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout;
    logic             push, perr_set, ferr_set;
    logic             pop, do_push;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    // Synchronisers idle high so a reset never fabricates a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall    = clk_s3 & ~clk_s2;
    assign timeout = (state != S_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_next = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
                S_PARITY: state_next = S_STOP;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Stop bit low outranks a parity fault.
    always_comb begin
        push     = 1'b0;
        perr_set = 1'b0;
        ferr_set = timeout;
        if (state == S_STOP && fall) begin
            if (!dat_s2)                 ferr_set = 1'b1;
            else if (^{shreg, par_bit})  push     = 1'b1;
            else                         perr_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= perr_set;
            frame_err  <= ferr_set;
            if (state == S_IDLE || fall) to_cnt <= '0;
            else                         to_cnt <= to_cnt + 1'b1;
            if (fall) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_bit <= dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    assign pop     = valid & ready;
    assign do_push = push & ((count != CNT_W'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)              rd_ptr   <= rd_ptr + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign valid      = (count != '0);
    assign data_out   = mem[rd_ptr];
    assign fifo_count = count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_receiver.sv
//------------------------------------------------------------------------------
// tb_ps2_frame_receiver: self-checking bench for the PS/2 frame receiver
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_frame_receiver;

    localparam int DEPTH = 8;
    localparam int TOC   = 200;
    localparam int CLK_P = 10;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, ready;
    logic       valid, overflow, parity_err, frame_err;
    logic [7:0] data_out;
    logic [3:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pe_cnt   = 0;
    int fe_cnt   = 0;
    logic [7:0] popped[$];
    logic [7:0] model[$];

    ps2_frame_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOC), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ready(ready),
        .valid(valid), .data_out(data_out), .fifo_count(fifo_count),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #(CLK_P/2) clk = ~clk;

    // Observe the consumer side and error pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) popped.push_back(data_out);
            if (parity_err) pe_cnt++;
            if (frame_err)  fe_cnt++;
        end
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit good_par, input bit stop);
        logic p;
        p = good_par ? ~(^d) : (^d);
        return {stop, p, d, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            #(HALF*CLK_P) ps2_clk = 1'b0;
            #(HALF*CLK_P) ps2_clk = 1'b1;
        end
        #(HALF*CLK_P) ps2_data = 1'b1;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 ready = r;
    endtask

    task automatic drain();
        set_ready(1'b1);
        repeat (DEPTH + 4) @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({valid, fifo_count, data_out, overflow, parity_err, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b cnt=%0d data=%h ovf=%b pe=%b fe=%b, want all 0",
                     valid, fifo_count, data_out, overflow, parity_err, frame_err);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got valid=%b cnt=%0d, want 0 0", valid, fifo_count);
        end
    endtask

    task automatic test_basic();
        popped.delete();
        set_ready(1'b1);
        ps2_bits(mk_frame(8'h1C, 1, 1), 11);
        @(negedge clk);
        n_checks++;
        if (popped.size() != 1 || popped[0] !== 8'h1C) begin
            n_fail++;
            $display("FAIL basic_1C: got %0d bytes first=%h, want 1 byte 1c", popped.size(),
                     popped.size() ? popped[0] : 8'hxx);
        end
        n_checks++;
        if (fifo_count !== 4'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_empty: got cnt=%0d valid=%b, want 0 0", fifo_count, valid);
        end
        set_ready(1'b0);
    endtask

    task automatic test_back_to_back();
        popped.delete();
        ps2_bits(mk_frame(8'hF0, 1, 1), 11);
        ps2_bits(mk_frame(8'h1C, 1, 1), 11);
        repeat (10) @(negedge clk);
        n_checks++;
        if (fifo_count !== 4'd2 || data_out !== 8'hF0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold: got cnt=%0d data=%h valid=%b, want 2 f0 1", fifo_count, data_out, valid);
        end
        drain();
        n_checks++;
        if (popped.size() != 2 || popped[0] !== 8'hF0 || popped[1] !== 8'h1C) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d bytes, want f0 1c", popped.size());
        end
    endtask

    task automatic test_errors();
        int pe0, fe0;
        pe0 = pe_cnt; fe0 = fe_cnt;
        ps2_bits(mk_frame(8'h12, 0, 1), 11);
        n_checks++;
        if (pe_cnt - pe0 != 1 || fe_cnt != fe0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL err_parity: got pe=%0d fe=%0d cnt=%0d, want 1 0 0", pe_cnt - pe0, fe_cnt - fe0, fifo_count);
        end
        pe0 = pe_cnt; fe0 = fe_cnt;
        ps2_bits(mk_frame(8'h12, 1, 0), 11);
        n_checks++;
        if (fe_cnt - fe0 != 1 || pe_cnt != pe0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL err_stop: got pe=%0d fe=%0d cnt=%0d, want 0 1 0", pe_cnt - pe0, fe_cnt - fe0, fifo_count);
        end
        pe0 = pe_cnt; fe0 = fe_cnt;
        ps2_bits(mk_frame(8'h12, 0, 0), 11);
        n_checks++;
        if (fe_cnt - fe0 != 1 || pe_cnt != pe0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL err_priority: got pe=%0d fe=%0d cnt=%0d, want 0 1 0", pe_cnt - pe0, fe_cnt - fe0, fifo_count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int pe0, fe0, exp_pe, exp_fe;
            model.delete(); popped.delete();
            pe0 = pe_cnt; fe0 = fe_cnt; exp_pe = 0; exp_fe = 0;
            for (int k = 0; k < 4; k++) begin
                logic [7:0] d;
                int kind;
                d    = 8'($urandom);
                kind = $urandom_range(0, 4);
                ps2_bits(mk_frame(d, kind != 0, kind != 1), 11);
                if (kind == 1)      exp_fe++;
                else if (kind == 0) exp_pe++;
                else                model.push_back(d);
            end
            n_checks++;
            if (fifo_count !== 4'(model.size()) || pe_cnt - pe0 != exp_pe || fe_cnt - fe0 != exp_fe) begin
                n_fail++;
                $display("FAIL rand_counts round %0d: got cnt=%0d pe=%0d fe=%0d, want %0d %0d %0d", r,
                         fifo_count, pe_cnt - pe0, fe_cnt - fe0, model.size(), exp_pe, exp_fe);
            end
            drain();
            n_checks++;
            if (popped != model) begin
                n_fail++;
                $display("FAIL rand_data round %0d: got %0d bytes, want %0d in order", r, popped.size(), model.size());
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes[9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        model.delete(); popped.delete();
        foreach (codes[i]) begin
            ps2_bits(mk_frame(codes[i], 1, 1), 11);
            if (model.size() < DEPTH) model.push_back(codes[i]);
        end
        n_checks++;
        if (fifo_count !== 4'(DEPTH) || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b, want %0d 1", fifo_count, overflow, DEPTH);
        end
        drain();
        n_checks++;
        if (popped != model) begin
            n_fail++;
            $display("FAIL ovf_drain: got %0d bytes, want first %0d in order", popped.size(), model.size());
        end
        n_checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b cnt=%0d, want 1 0", overflow, fifo_count);
        end
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        popped.delete();
        ps2_bits(mk_frame(8'hAA, 1, 1), 5);
        repeat (100) @(negedge clk);
        n_checks++;
        if (fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL to_early: got %0d frame_err pulses, want 0", fe_cnt - fe0);
        end
        repeat (150) @(negedge clk);
        n_checks++;
        if (fe_cnt - fe0 != 1 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL to_abort: got fe=%0d cnt=%0d, want 1 0", fe_cnt - fe0, fifo_count);
        end
        ps2_bits(mk_frame(8'h45, 1, 1), 11);
        drain();
        n_checks++;
        if (popped.size() != 1 || popped[0] !== 8'h45) begin
            n_fail++;
            $display("FAIL to_recover: got %0d bytes, want 45", popped.size());
        end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        ps2_bits(mk_frame(8'h1C, 1, 1), 11);
        ps2_bits(mk_frame(8'h32, 1, 1), 11);
        ps2_bits(mk_frame(8'h21, 1, 1), 11);
        n_checks++;
        if (fifo_count !== 4'd3) begin
            n_fail++;
            $display("FAIL rst_pre: got cnt=%0d, want 3", fifo_count);
        end
        ps2_bits(mk_frame(8'h77, 1, 1), 6);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({valid, fifo_count, data_out, overflow, parity_err, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b cnt=%0d data=%h ovf=%b, want all 0",
                     valid, fifo_count, data_out, overflow);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fe0 = fe_cnt;
        repeat (TOC + 50) @(negedge clk);
        n_checks++;
        if (fe_cnt != fe0 || fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_discard: got fe=%0d cnt=%0d, want 0 0", fe_cnt - fe0, fifo_count);
        end
        popped.delete();
        ps2_bits(mk_frame(8'h58, 1, 1), 11);
        drain();
        n_checks++;
        if (popped.size() != 1 || popped[0] !== 8'h58) begin
            n_fail++;
            $display("FAIL rst_recover: got %0d bytes, want 58", popped.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_random();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
